motoro3_cmd_ramp: RTL and testbench
===================================

Name: motoro3_cmd_ramp

Overview:
- Parametrised command conditioner between the asynchronous motor-control inputs (start, direction, frequency code) and the 3-phase core (motoro3_real class).
- Synchronises inputs with SYNC_STAGES rising-edge flops, then clamps the frequency code to [FREQ_MIN, FREQ_MAX].
- Slews the applied code toward the target at a programmable rate, and sequences stop and direction reversal: ramp to FREQ_START, dead time, flip direction, ramp back.
- Frequency code is a period code: larger value = slower motor.

Parameters:
- FREQ_W, 10: width of frequency code.
- FREQ_MIN, 1000: lower clamp; inputs below it are forced to FREQ_MIN.
- FREQ_MAX, 1023: upper clamp; must be ≤ 2^FREQ_W−1.
- FREQ_START, 1023: slowest code; start/stop point of every ramp; FREQ_MIN ≤ FREQ_START ≤ FREQ_MAX.
- STEP, 1: code change per ramp tick.
- TICK_DIV, 1000: clk cycles per ramp tick; ≥ 1.
- DEAD_CYC, 100: clk cycles with start low during reversal; ≥ 1.
- SYNC_STAGES, 2: synchroniser depth; ≥ 2.

Ports:
- clk  in  1  system clock (10 MHz).
- rst  in  1  asynchronous, active-high reset.
- m3start  in  1  asynchronous run request.
- m3invOrStop  in  1  asynchronous direction select (1 = inverse).
- m3freq  in  FREQ_W  asynchronous target frequency code.
- m3start_o  out  1  run enable to core.
- m3dir_o  out  1  applied direction to core.
- m3freq_o  out  FREQ_W  applied (ramped) code to core.
- state_o  out  3  current FSM state encoding.
- at_target_o  out  1  high when m3freq_o equals the clamped target in RUN.

Behaviour:
- Reset (async, rst=1): all sync flops 0.
  - m3start_o=0, m3dir_o=0, m3freq_o=FREQ_START, state_o=IDLE, at_target_o=0, tick counter 0, dead counter 0.
- Sync:
  - Each input passes SYNC_STAGES posedge flops. All flops use posedge clk; no negedge stages.
  - tgt = clamp(sync freq) is registered, giving one extra cycle.
  - Input-to-FSM latency is SYNC_STAGES+1 cycles.
- Tick:
  - A free-running counter counts 0..TICK_DIV−1; tick=1 for one cycle at wrap.
  - Counter is cleared on every state entry, so the first step after entry comes TICK_DIV cycles later.
- Step rule, on tick toward value v:
  - If |m3freq_o − v| ≤ STEP, then m3freq_o=v.
  - Otherwise m3freq_o moves by ±STEP toward v.
  - The result never leaves [FREQ_MIN, FREQ_MAX]; no wrap-around.
- States: IDLE=0, ACCEL=1, RUN=2, DECEL=3, DEAD=4.
- IDLE:
  - m3start_o=0, m3freq_o=FREQ_START.
  - When start_s=1: m3dir_o←dir_s, go to ACCEL.
- ACCEL:
  - m3start_o=1; step toward tgt.
  - start_s=0 or dir_s≠m3dir_o: go to DECEL.
  - m3freq_o==tgt: go to RUN.
- RUN:
  - m3start_o=1; at_target_o = (m3freq_o==tgt).
  - If tgt changes, step toward the new tgt in RUN; no state change.
  - start_s=0 or dir_s≠m3dir_o: go to DECEL.
- DECEL:
  - m3start_o=1; step toward FREQ_START.
  - On reaching FREQ_START: if start_s=0, go to IDLE; else go to DEAD.
  - If the cause clears mid-ramp (start back to 1 and dir_s==m3dir_o): go to ACCEL with no reversal.
- DEAD:
  - m3start_o=0 for exactly DEAD_CYC cycles.
  - Then m3dir_o←dir_s, go to ACCEL.
  - If start_s=0 during DEAD, go to IDLE when the count ends.
- Simultaneous stop and reverse in RUN: stop wins at the FREQ_START decision point; go to IDLE, direction unchanged.
- m3dir_o changes only on the IDLE→ACCEL and DEAD→ACCEL transitions, never while m3start_o=1.
- Target equal to FREQ_START: ACCEL→RUN on the cycle after entry, with no tick.
- Reset mid-ramp: outputs return to reset values immediately (asynchronous).
- All outputs are registered.

Test Plan:
- Reset with m3freq=500 → m3freq_o=1023, m3start_o=0, state_o=0; after release and start=1, tgt reads 1000 (clamped).
- TICK_DIV=4, STEP=1, start=1, m3freq=1010 → state 1; m3freq_o goes 1023→1022… one step per 4 cycles, reaches 1010 after 13 ticks, then state 2 and at_target_o=1.
- In RUN, drop start → m3start_o stays 1 through DECEL; m3freq_o ramps to 1023; then state 0 and m3start_o=0.
- In RUN with dir=0, set m3invOrStop=1 → DECEL to 1023; DEAD for exactly DEAD_CYC cycles with m3start_o=0; m3dir_o=1 at ACCEL entry; ramp back to target.
- During DECEL, restore dir to original → back to ACCEL, DEAD never entered, m3dir_o unchanged.
- STEP=5 with target 1020 → single tick lands exactly on 1020, no overshoot; glitch on m3start shorter than 1 cycle is never seen at m3start_o.

Source files
------------

// File: rtl/motoro3_cmd_ramp.sv
// motoro3_cmd_ramp: synchronises, clamps and slew-limits motor commands, sequencing stop and reversal
module motoro3_cmd_ramp #(
  parameter int FREQ_W      = 10,
  parameter int FREQ_MIN    = 1000,
  parameter int FREQ_MAX    = 1023,
  parameter int FREQ_START  = 1023,
  parameter int STEP        = 1,
  parameter int TICK_DIV    = 1000,
  parameter int DEAD_CYC    = 100,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m3start,
  input  logic              m3invOrStop,
  input  logic [FREQ_W-1:0] m3freq,
  output logic              m3start_o,
  output logic              m3dir_o,
  output logic [FREQ_W-1:0] m3freq_o,
  output logic [2:0]        state_o,
  output logic              at_target_o
);
  typedef enum logic [2:0] {IDLE = 3'd0, ACCEL = 3'd1, RUN = 3'd2, DECEL = 3'd3, DEAD = 3'd4} state_t;
  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int DW = $clog2(DEAD_CYC + 1);
  localparam logic [FREQ_W-1:0] F_MIN   = FREQ_W'(FREQ_MIN);
  localparam logic [FREQ_W-1:0] F_MAX   = FREQ_W'(FREQ_MAX);
  localparam logic [FREQ_W-1:0] F_START = FREQ_W'(FREQ_START);
  localparam logic [FREQ_W-1:0] F_STEP  = FREQ_W'(STEP);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYC - 1);
  logic [SYNC_STAGES-1:0] start_q, dir_q;
  logic [FREQ_W-1:0] freq_q [SYNC_STAGES];
  logic start_s, dir_s, tick, cause, start_n, dir_n;
  logic [FREQ_W-1:0] tgt, tgt_n, goal, diff, stepped, freq_n;
  logic [TW-1:0] tick_cnt;
  logic [DW-1:0] dead_cnt;
  state_t state, state_n;
  // input synchronisers; start/dir get one extra flop so they line up with the registered clamp of the code
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      start_q <= '0;
      dir_q   <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) freq_q[i] <= '0;
      start_s <= 1'b0;
      dir_s   <= 1'b0;
      tgt     <= F_MIN;
    end else begin
      start_q   <= {start_q[SYNC_STAGES-2:0], m3start};
      dir_q     <= {dir_q[SYNC_STAGES-2:0], m3invOrStop};
      freq_q[0] <= m3freq;
      for (int i = 1; i < SYNC_STAGES; i++) freq_q[i] <= freq_q[i-1];
      start_s   <= start_q[SYNC_STAGES-1];
      dir_s     <= dir_q[SYNC_STAGES-1];
      tgt       <= tgt_n;
    end
  assign tgt_n   = freq_q[SYNC_STAGES-1] < F_MIN ? F_MIN : (freq_q[SYNC_STAGES-1] > F_MAX ? F_MAX : freq_q[SYNC_STAGES-1]);
  assign tick    = tick_cnt == TICK_LAST;
  assign cause   = !start_s || dir_s != m3dir_o;
  assign goal    = state == DECEL ? F_START : tgt;
  assign diff    = m3freq_o > goal ? m3freq_o - goal : goal - m3freq_o;
  assign stepped = diff <= F_STEP ? goal : (m3freq_o > goal ? m3freq_o - F_STEP : m3freq_o + F_STEP);
  // sequencing of run, stop and reversal, plus the slewed code
  always_comb begin
    state_n = state;
    start_n = m3start_o;
    dir_n   = m3dir_o;
    freq_n  = m3freq_o;
    case (state)
      IDLE: begin
        freq_n = F_START;
        if (start_s) begin
          state_n = ACCEL;
          start_n = 1'b1;
          dir_n   = dir_s;
        end
      end
      ACCEL: state_n = cause ? DECEL : (m3freq_o == tgt ? RUN : ACCEL);
      RUN: state_n = cause ? DECEL : RUN;
      DECEL:
        if (!cause) state_n = ACCEL;
        else if (m3freq_o == F_START) begin
          state_n = start_s ? DEAD : IDLE;
          start_n = 1'b0;
        end
      DEAD:
        if (dead_cnt == DEAD_LAST) begin
          state_n = start_s ? ACCEL : IDLE;
          start_n = start_s;
          dir_n   = start_s ? dir_s : m3dir_o;
        end
      default: state_n = IDLE;
    endcase
    if (tick && state_n == state && (state == ACCEL || state == RUN || state == DECEL)) freq_n = stepped;
  end
  // state, registered outputs and the per-state tick/dead counters (both restart on every state entry)
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= IDLE;
      m3start_o   <= 1'b0;
      m3dir_o     <= 1'b0;
      m3freq_o    <= F_START;
      at_target_o <= 1'b0;
      tick_cnt    <= '0;
      dead_cnt    <= '0;
    end else begin
      state       <= state_n;
      m3start_o   <= start_n;
      m3dir_o     <= dir_n;
      m3freq_o    <= freq_n;
      at_target_o <= state_n == RUN && freq_n == tgt_n;
      tick_cnt    <= (state_n != state || tick) ? '0 : tick_cnt + 1'b1;
      dead_cnt    <= state_n != state ? '0 : dead_cnt + 1'b1;
    end
  assign state_o = state;
endmodule

// File: tb/tb_motoro3_cmd_ramp.sv
// tb_motoro3_cmd_ramp: scoreboard bench for the command ramp, expected output changes queued by stimulus
module tb_motoro3_cmd_ramp;
  typedef struct packed {logic [2:0] st; logic s; logic d; logic [9:0] f; logic at;} out_t;
  typedef struct {out_t o; int gap;} exp_t;
  logic clk = 1'b0, rst = 1'b0;
  logic start, dir, start5, dir5;
  logic [9:0] freq, freq5, m3freq_o, f5_o;
  logic m3start_o, m3dir_o, at_target_o, s5_o, d5_o, at5_o;
  logic [2:0] state_o, st5_o;
  exp_t q0[$], q1[$];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  motoro3_cmd_ramp #(.STEP(1), .TICK_DIV(4), .DEAD_CYC(6)) dut (
    .clk(clk), .rst(rst), .m3start(start), .m3invOrStop(dir), .m3freq(freq),
    .m3start_o(m3start_o), .m3dir_o(m3dir_o), .m3freq_o(m3freq_o), .state_o(state_o), .at_target_o(at_target_o));
  motoro3_cmd_ramp #(.STEP(5), .TICK_DIV(4), .DEAD_CYC(6)) dut5 (
    .clk(clk), .rst(rst), .m3start(start5), .m3invOrStop(dir5), .m3freq(freq5),
    .m3start_o(s5_o), .m3dir_o(d5_o), .m3freq_o(f5_o), .state_o(st5_o), .at_target_o(at5_o));
  task automatic chk(input string name, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask
  task automatic push(input int u, input logic [2:0] st, input logic s, input logic d, input int f, input logic at, input int gap);
    exp_t e;
    e.o = {st, s, d, 10'(f), at};
    e.gap = gap;
    if (u == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask
  task automatic ramp(input logic [2:0] st, input logic d, input int from, input int to);
    int f = from;
    while (f != to) begin
      f += (to > from) ? 1 : -1;
      push(0, st, 1'b1, d, f, 1'b0, 4);
    end
  endtask
  task automatic check(input int u, input out_t got, input int gap);
    exp_t e;
    n_chk++;
    if ((u == 0 ? q0.size() : q1.size()) == 0) begin
      n_fail++;
      $display("FAIL unexpected_change u%0d got st=%0d s=%b d=%b f=%0d at=%b want no change", u, got.st, got.s, got.d, got.f, got.at);
      return;
    end
    e = u == 0 ? q0.pop_front() : q1.pop_front();
    if (got !== e.o || (e.gap >= 0 && gap != e.gap)) begin
      n_fail++;
      $display("FAIL out_seq u%0d got st=%0d s=%b d=%b f=%0d at=%b gap=%0d want st=%0d s=%b d=%b f=%0d at=%b gap=%0d",
               u, got.st, got.s, got.d, got.f, got.at, gap, e.o.st, e.o.s, e.o.d, e.o.f, e.o.at, e.gap);
    end
  endtask
  task automatic wait_empty(input int u);
    for (int i = 0; i < 400 && (u == 0 ? q0.size() : q1.size()) != 0; i++) @(negedge clk);
    chk(u == 0 ? "pending_q0" : "pending_q1", u == 0 ? q0.size() : q1.size(), 0);
  endtask
  task automatic wait_f(input int f);
    for (int i = 0; i < 200 && m3freq_o != 10'(f); i++) @(negedge clk);
    chk("wait_freq", m3freq_o, f);
  endtask
  initial begin
    out_t prev, cur;
    int since = 0;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = {state_o, m3start_o, m3dir_o, m3freq_o, at_target_o};
      since++;
      if (rst) begin
        prev = cur;
        since = 0;
      end else if (cur != prev) begin
        check(0, cur, since);
        prev = cur;
        since = 0;
      end
    end
  end
  initial begin
    out_t prev, cur;
    int since = 0;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = {st5_o, s5_o, d5_o, f5_o, at5_o};
      since++;
      if (rst) begin
        prev = cur;
        since = 0;
      end else if (cur != prev) begin
        check(1, cur, since);
        prev = cur;
        since = 0;
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    start = 0; dir = 0; freq = 10'd500; start5 = 0; dir5 = 0; freq5 = 10'd1020;
    #1 rst = 1'b1;
    #1;
    chk("rst_freq", m3freq_o, 1023);
    chk("rst_start", m3start_o, 0);
    chk("rst_dir", m3dir_o, 0);
    chk("rst_state", state_o, 0);
    chk("rst_at", at_target_o, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("tgt_clamp", dut.tgt, 1000);
    push(0, 1, 1, 0, 1023, 0, -1); ramp(1, 0, 1023, 1010); push(0, 2, 1, 0, 1010, 1, 1);
    freq = 10'd1010; start = 1;
    wait_empty(0);
    push(0, 3, 1, 0, 1010, 0, -1); ramp(3, 0, 1010, 1023); push(0, 0, 0, 0, 1023, 0, 1);
    start = 0;
    wait_empty(0);
    push(0, 1, 1, 0, 1023, 0, -1); ramp(1, 0, 1023, 1010); push(0, 2, 1, 0, 1010, 1, 1);
    start = 1;
    wait_empty(0);
    push(0, 3, 1, 0, 1010, 0, -1); ramp(3, 0, 1010, 1023);
    push(0, 4, 0, 0, 1023, 0, 1); push(0, 1, 1, 1, 1023, 0, 6);
    ramp(1, 1, 1023, 1010); push(0, 2, 1, 1, 1010, 1, 1);
    dir = 1;
    wait_empty(0);
    push(0, 3, 1, 1, 1010, 0, -1); ramp(3, 1, 1010, 1014); push(0, 1, 1, 1, 1014, 0, 2);
    ramp(1, 1, 1014, 1010); push(0, 2, 1, 1, 1010, 1, 1);
    dir = 0;
    wait_f(1013);
    repeat (2) @(negedge clk);
    dir = 1;
    wait_empty(0);
    push(0, 3, 1, 1, 1010, 0, -1); ramp(3, 1, 1010, 1023); push(0, 0, 0, 1, 1023, 0, 1);
    start = 0; dir = 0;
    wait_empty(0);
    push(0, 1, 1, 1, 1023, 0, -1); push(0, 1, 1, 1, 1022, 0, 4); push(0, 1, 1, 1, 1021, 0, 4);
    start = 1; dir = 1;
    wait_f(1021);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_freq", m3freq_o, 1023);
    chk("mid_rst_start", m3start_o, 0);
    chk("mid_rst_dir", m3dir_o, 0);
    chk("mid_rst_state", state_o, 0);
    start = 0; dir = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push(1, 1, 1, 0, 1023, 0, -1); push(1, 1, 1, 0, 1020, 0, 4); push(1, 2, 1, 0, 1020, 1, 1);
    start5 = 1;
    wait_empty(1);
    @(negedge clk);
    #1 start5 = 0;
    #3 start5 = 1;
    repeat (20) @(negedge clk);
    chk("glitch_start", s5_o, 1);
    chk("glitch_state", st5_o, 2);
    chk("q0_left", q0.size(), 0);
    chk("q1_left", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
